// File: rtl/cache_meta_ctrl_if.sv
// cache_meta_ctrl_if: request/response channel between the cache FSM (master) and cache_meta_ctrl (slave)
interface cache_meta_ctrl_if #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 23
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_dirty;
    logic             resp_valid;
    logic             resp_hit;
    logic             resp_vld;
    logic             resp_dirty;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_idx, req_tag, req_dirty,
        input  req_ready, resp_valid, resp_hit, resp_vld, resp_dirty, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_idx, req_tag, req_dirty,
        output req_ready, resp_valid, resp_hit, resp_vld, resp_dirty, resp_tag
    );
endinterface

// File: rtl/cache_meta_ctrl.sv
// cache_meta_ctrl: owner of the 64-set meta RAM: post-reset clear, request service and flush walk.
// Defining CACHE_META_STAT_EN adds saturating stat_hit/stat_miss lookup counters.
module cache_meta_ctrl #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 23
) (
    input  logic             clock,
    input  logic             reset,
    cache_meta_ctrl_if.slave req_bus,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [IDX_W-1:0] wb_idx,
    output logic [TAG_W-1:0] wb_tag,
    output logic             init_done,
    output logic             ram_en,
    output logic             ram_wr,
    output logic [IDX_W-1:0] ram_addr,
    output logic             ram_wvalid,
    output logic             ram_wdirty,
    output logic [TAG_W-1:0] ram_wtag,
    input  logic             ram_valid,
    input  logic             ram_dirty,
    input  logic [TAG_W-1:0] ram_tag
`ifdef CACHE_META_STAT_EN
    ,
    output logic [31:0]      stat_hit,
    output logic [31:0]      stat_miss
`endif
);
    typedef enum logic [3:0] {INIT, IDLE, WR, RD, RSP, F_RD, F_CHK, F_WB, F_CLR} state_t;

    localparam logic [1:0]       OP_LOOKUP = 2'd0;
    localparam logic [1:0]       OP_MARK   = 2'd1;
    localparam logic [1:0]       OP_FILL   = 2'd2;
    localparam logic [1:0]       OP_INVAL  = 2'd3;
    localparam logic [IDX_W-1:0] LAST      = '1;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [TAG_W-1:0] tag_q;
    logic             ready_q;
    logic             lookup_q;
    logic             resp_valid_q;
    logic             hit;

    // a flush request wins over a request presented in the same IDLE cycle
    assign req_bus.req_ready  = ready_q & ~flush_req;
    assign req_bus.resp_valid = resp_valid_q;
    // lookup fields come straight off the registered RAM read port so they land in RSP
    assign hit                = lookup_q & ram_valid & (ram_tag == tag_q);
    assign req_bus.resp_hit   = hit;
    assign req_bus.resp_vld   = lookup_q & ram_valid;
    assign req_bus.resp_dirty = lookup_q & ram_dirty;
    assign req_bus.resp_tag   = lookup_q ? ram_tag : '0;

    // sequencer: clear walk, request service and flush walk, all outputs registered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= INIT;
            cnt          <= '0;
            tag_q        <= '0;
            ready_q      <= 1'b0;
            lookup_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            flush_busy   <= 1'b0;
            flush_done   <= 1'b0;
            wb_valid     <= 1'b0;
            wb_idx       <= '0;
            wb_tag       <= '0;
            init_done    <= 1'b0;
            ram_en       <= 1'b0;
            ram_wr       <= 1'b0;
            ram_addr     <= '0;
            ram_wvalid   <= 1'b0;
            ram_wdirty   <= 1'b0;
            ram_wtag     <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            lookup_q     <= 1'b0;
            flush_done   <= 1'b0;
            ram_en       <= 1'b0;
            ram_wr       <= 1'b0;
            ram_wvalid   <= 1'b0;
            ram_wdirty   <= 1'b0;
            ram_wtag     <= '0;
            case (state)
                INIT: begin
                    ram_en   <= 1'b1;
                    ram_wr   <= 1'b1;
                    ram_addr <= cnt;
                    cnt      <= cnt + IDX_W'(1);
                    if (cnt == LAST) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                        ready_q   <= 1'b1;
                    end
                end
                IDLE: begin
                    if (flush_req) begin
                        state      <= F_RD;
                        ready_q    <= 1'b0;
                        flush_busy <= 1'b1;
                        cnt        <= '0;
                        ram_en     <= 1'b1;
                        ram_addr   <= '0;
                    end else if (req_bus.req_valid) begin
                        ready_q  <= 1'b0;
                        ram_en   <= 1'b1;
                        ram_addr <= req_bus.req_idx;
                        tag_q    <= req_bus.req_tag;
                        if (req_bus.req_op == OP_LOOKUP) begin
                            state <= RD;
                        end else begin
                            state        <= WR;
                            resp_valid_q <= 1'b1;
                            ram_wr       <= 1'b1;
                            ram_wvalid   <= req_bus.req_op != OP_INVAL;
                            ram_wdirty   <= (req_bus.req_op == OP_MARK) |
                                            ((req_bus.req_op == OP_FILL) & req_bus.req_dirty);
                            ram_wtag     <= req_bus.req_tag;
                        end
                    end
                end
                WR: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                RD: begin
                    state        <= RSP;
                    resp_valid_q <= 1'b1;
                    lookup_q     <= 1'b1;
                end
                RSP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                F_RD: state <= F_CHK;
                F_CHK: begin
                    if (ram_valid & ram_dirty) begin
                        state    <= F_WB;
                        wb_valid <= 1'b1;
                        wb_idx   <= cnt;
                        wb_tag   <= ram_tag;
                    end else begin
                        state    <= F_CLR;
                        ram_en   <= 1'b1;
                        ram_wr   <= 1'b1;
                        ram_addr <= cnt;
                    end
                end
                F_WB: begin
                    if (wb_ready) begin
                        state    <= F_CLR;
                        wb_valid <= 1'b0;
                        ram_en   <= 1'b1;
                        ram_wr   <= 1'b1;
                        ram_addr <= cnt;
                    end
                end
                F_CLR: begin
                    cnt <= cnt + IDX_W'(1);
                    if (cnt == LAST) begin
                        state      <= IDLE;
                        ready_q    <= 1'b1;
                        flush_busy <= 1'b0;
                        flush_done <= 1'b1;
                    end else begin
                        state    <= F_RD;
                        ram_en   <= 1'b1;
                        ram_addr <= cnt + IDX_W'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef CACHE_META_STAT_EN
    // saturating hit/miss counters, restarted when a flush completes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_hit  <= '0;
            stat_miss <= '0;
        end else if (state == F_CLR && cnt == LAST) begin
            stat_hit  <= '0;
            stat_miss <= '0;
        end else if (lookup_q) begin
            if (hit) stat_hit <= stat_hit + {31'd0, ~&stat_hit};
            else stat_miss <= stat_miss + {31'd0, ~&stat_miss};
        end
    end
`endif
endmodule

// File: tb/tb_cache_meta_ctrl.sv
// tb_cache_meta_ctrl: scoreboard bench for cache_meta_ctrl with a behavioural meta RAM
module tb_cache_meta_ctrl;
    localparam logic [1:0] LK = 2'd0, MK = 2'd1, FL = 2'd2, IV = 2'd3;

    typedef struct {
        logic        lk;
        logic        hit;
        logic        vld;
        logic        dirty;
        logic [22:0] tag;
        int          acc;
        string       name;
    } exp_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [22:0] tag;
    } wb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush_req = 1'b0;
    logic        flush_busy, flush_done, wb_valid, init_done;
    logic        wb_ready;
    logic [5:0]  wb_idx, ram_addr;
    logic [22:0] wb_tag, ram_wtag, ram_tag;
    logic        ram_en, ram_wr, ram_wvalid, ram_wdirty, ram_valid, ram_dirty;
    logic        mem_v [64];
    logic        mem_d [64];
    logic [22:0] mem_t [64];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    exp_t        respq [$];
    wb_t         wbq [$];

    cache_meta_ctrl_if #(.IDX_W(6), .TAG_W(23)) bus ();

    cache_meta_ctrl #(.IDX_W(6), .TAG_W(23)) dut (
        .clock(clock), .reset(reset), .req_bus(bus),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_tag(wb_tag),
        .init_done(init_done),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_wvalid(ram_wvalid), .ram_wdirty(ram_wdirty), .ram_wtag(ram_wtag),
        .ram_valid(ram_valid), .ram_dirty(ram_dirty), .ram_tag(ram_tag)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // meta RAM model; reloaded with valid/dirty garbage while reset is held so the clear walk matters
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                mem_v[i] <= 1'b1;
                mem_d[i] <= 1'b1;
                mem_t[i] <= 23'(i + 100);
            end
        end else if (ram_en) begin
            if (ram_wr) begin
                mem_v[ram_addr] <= ram_wvalid;
                mem_d[ram_addr] <= ram_wdirty;
                mem_t[ram_addr] <= ram_wtag;
            end else begin
                ram_valid <= mem_v[ram_addr];
                ram_dirty <= mem_d[ram_addr];
                ram_tag   <= mem_t[ram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // response monitor: pops the scoreboard whenever the DUT presents a response
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && bus.resp_valid) begin
                if (respq.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    e = respq.pop_front();
                    chk({e.name, "_lat"}, cyc - e.acc, e.lk ? 2 : 1);
                    chk({e.name, "_hit"}, bus.resp_hit, e.hit);
                    if (e.lk) begin
                        chk({e.name, "_vld"}, bus.resp_vld, e.vld);
                        chk({e.name, "_dirty"}, bus.resp_dirty, e.dirty);
                        chk({e.name, "_tag"}, bus.resp_tag, e.tag);
                    end
                end
            end
        end
    end

    // flush completion monitor
    initial begin
        forever begin
            @(negedge clock);
            if (flush_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", flush_busy, 0);
            end
        end
    end

    // writeback sink: holds wb_ready low 4 cycles per line, checks offered line every cycle
    initial begin
        int stall;
        stall = 0;
        wb_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset || wb_ready) begin
                wb_ready = 1'b0;
                stall = 0;
            end else if (wb_valid) begin
                if (wbq.size() == 0) begin
                    chk("wb_unexpected", 1, 0);
                    wb_ready = 1'b1;
                end else begin
                    chk("wb_idx", wb_idx, wbq[0].idx);
                    chk("wb_tag", wb_tag, wbq[0].tag);
                    if (stall < 4) stall++;
                    else begin
                        wb_ready = 1'b1;
                        void'(wbq.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [5:0] idx, input logic [22:0] tag,
                          input logic d, input logic eh, input logic ev, input logic ed,
                          input logic [22:0] et, input string nm, output int acc);
        exp_t e;
        int   n;
        n = 0;
        acc = -1;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_idx   = idx;
        bus.req_tag   = tag;
        bus.req_dirty = d;
        #1;
        while (!bus.req_ready && n < 1000) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!bus.req_ready) begin
            chk({nm, "_accept_timeout"}, 0, 1);
        end else begin
            acc     = cyc;
            e.lk    = (op == LK);
            e.hit   = eh;
            e.vld   = ev;
            e.dirty = ed;
            e.tag   = et;
            e.acc   = acc;
            e.name  = nm;
            respq.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        #1;
        while (!bus.req_ready && n < 1000) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("idle_timeout", bus.req_ready, 1);
    endtask

    task automatic start_flush(output int c0);
        wait_idle();
        flush_req = 1'b1;
        @(posedge clock);
        #1;
        flush_req = 1'b0;
        c0 = cyc;
        chk("flush_busy_rise", flush_busy, 1);
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("flush_done_timeout", done_cnt, d0 + 1);
    endtask

    task automatic init_walk();
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            chk("init_walk", {ram_en, ram_wr, ram_addr, init_done}, {1'b1, 1'b1, 6'(i), i == 63});
        end
    endtask

    initial begin
        int a1, a2, c0, d0, nv, n;
        bus.req_valid = 1'b0;
        bus.req_op    = LK;
        bus.req_idx   = '0;
        bus.req_tag   = '0;
        bus.req_dirty = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outs", {init_done, bus.req_ready, ram_en, ram_wr, bus.resp_valid,
                           wb_valid, flush_busy, flush_done}, 0);
        chk("reset_addr", ram_addr, 0);
        reset = 1'b1;
        init_walk();
        do_req(FL, 5, 23'h12345, 0, 0, 0, 0, 0, "fill5", a1);
        do_req(LK, 5, 23'h12345, 0, 1, 1, 0, 23'h12345, "lk5_hit", a1);
        do_req(LK, 5, 23'h00001, 0, 0, 1, 0, 23'h12345, "lk5_miss", a2);
        chk("lookup_spacing", a2 - a1, 3);
        do_req(MK, 5, 23'h12345, 0, 0, 0, 0, 0, "mark5", a1);
        do_req(LK, 5, 23'h12345, 0, 1, 1, 1, 23'h12345, "lk5_dirty", a1);
        do_req(LK, 7, 23'h00000, 0, 0, 0, 0, 23'h00000, "lk7_cleared", a1);
        do_req(IV, 5, 23'h12345, 0, 0, 0, 0, 0, "inval5", a1);
        do_req(LK, 5, 23'h12345, 0, 0, 0, 0, 23'h12345, "lk5_inval", a1);
        do_req(FL, 63, 23'h7FFFFF, 1, 0, 0, 0, 0, "fill63", a1);
        do_req(LK, 63, 23'h7FFFFF, 0, 1, 1, 1, 23'h7FFFFF, "lk63", a1);
        do_req(FL, 3, 23'h00AAA, 1, 0, 0, 0, 0, "fill3", a1);
        do_req(FL, 63, 23'h00BBB, 1, 0, 0, 0, 0, "fill63b", a1);
        do_req(FL, 20, 23'h00555, 0, 0, 0, 0, 0, "fill20", a1);
        wbq.push_back('{idx: 6'd3, tag: 23'h00AAA});
        wbq.push_back('{idx: 6'd63, tag: 23'h00BBB});
        wait_idle();
        flush_req     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = LK;
        bus.req_idx   = 6'd3;
        bus.req_tag   = 23'h00AAA;
        #1;
        chk("flush_prio_ready", bus.req_ready, 0);
        @(posedge clock);
        #1;
        flush_req = 1'b0;
        chk("flush_prio_busy", flush_busy, 1);
        do_req(LK, 3, 23'h00AAA, 0, 0, 0, 0, 0, "lk3_after_flush", a1);
        chk("req_after_done", a1, done_cyc);
        chk("done_count1", done_cnt, 1);
        chk("wb_drained", wbq.size(), 0);
        nv = 0;
        for (int i = 0; i < 64; i++) nv += int'(mem_v[i]);
        chk("all_invalid", nv, 0);
        start_flush(c0);
        wait_done(1);
        chk("clean_flush_cycles", done_cyc - c0, 192);
        do_req(LK, 20, 23'h00555, 0, 0, 0, 0, 0, "lk20_flushed", a1);
        do_req(FL, 10, 23'h00001, 1, 0, 0, 0, 0, "fill10", a1);
        wbq.push_back('{idx: 6'd10, tag: 23'h00001});
        start_flush(c0);
        n = 0;
        while (!wb_valid && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("wb_seen", wb_valid, 1);
        d0 = done_cnt;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_state_outs", {flush_busy, init_done, ram_en, bus.req_ready}, 0);
        wbq.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        init_walk();
        chk("no_done_after_reset", done_cnt, d0);
        do_req(LK, 10, 23'h00001, 0, 0, 0, 0, 0, "lk10_reinit", a1);
        repeat (5) @(negedge clock);
        chk("resp_outstanding", respq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end
endmodule
